bcd_sync_down_cntr: RTL and testbench



---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_down_digit.sv | 60 ++++++
 rtl/bcd_sync_down_cntr_chk.sv | 52 +++++
 rtl/bcd_sync_down_cntr.sv | 93 +++++++++
 tb/tb_bcd_sync_down_cntr.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and helpers for the BCD counter family.
//   BCD_W        : width of one BCD digit
//   BCD_MAX      : largest legal digit value (9)
//   BCD_ZERO     : digit value zero
//   bcd_sanitise : clamps a raw nibble into the legal BCD range 0..9
//   bcd_is_valid : true when a nibble holds a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    // Values A..F are not BCD; they are pinned to 9 so the count stays legal.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble);
        logic [3:0] result;
        if (nibble > BCD_MAX) begin
            result = BCD_MAX;
        end else begin
            result = nibble;
        end
        return result;
    endfunction

    function automatic logic bcd_is_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One decade of the synchronous BCD down-counter.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (digit -> 0)
//   load       : synchronous load strobe (wins over borrow_in)
//   load_nib   : raw preset nibble, sanitised to 0..9 before it is stored
//   borrow_in  : decrement request from the less significant digits
//   digit      : registered digit value
//   is_zero    : digit == 0
//   borrow_out : borrow forwarded to the next more significant digit
// -----------------------------------------------------------------------------
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             is_zero,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    // Next-state: load, else decrement on borrow (0 wraps to 9), else hold.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sanitise(load_nib);
        end else if (borrow_in) begin
            if (digit_q == BCD_ZERO) begin
                digit_d = BCD_MAX;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign is_zero    = (digit_q == BCD_ZERO);
    // A borrow passes through only a digit that is itself zero.
    assign borrow_out = borrow_in & is_zero;

endmodule : bcd_down_digit

// File: rtl/bcd_sync_down_cntr_chk.sv
// -----------------------------------------------------------------------------
// bcd_sync_down_cntr_chk
// Run-time property checks for bcd_sync_down_cntr. Observes the counter
// outputs only; drives nothing. Checks are armed after the first reset edge.
// Ports:
//   clk, rst   : counter clock and synchronous reset
//   count      : counter value
//   zero       : zero flag
//   underflow  : wrap pulse
// -----------------------------------------------------------------------------
module bcd_sync_down_cntr_chk
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    input logic [4*DIGITS-1:0]   count,
    input logic                  zero,
    input logic                  underflow
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    logic armed_q;
    logic underflow_prev_q;

    // Arm on the first reset, then remember last cycle's underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q          <= 1'b1;
            underflow_prev_q <= 1'b0;
        end else begin
            armed_q          <= armed_q;
            underflow_prev_q <= underflow;
        end
    end

    // Output invariants sampled at every clock once armed.
    always_ff @(posedge clk) begin
        if (armed_q == 1'b1) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                assert (bcd_is_valid(count[4*i +: 4]));
            end
            assert (zero == (count == '0));
            assert (!underflow || (WRAP && (count == ALL_NINES)));
            assert (!(underflow && underflow_prev_q));
        end
    end

endmodule : bcd_sync_down_cntr_chk

// File: rtl/bcd_sync_down_cntr.sv
// -----------------------------------------------------------------------------
// bcd_sync_down_cntr
// Synchronous multi-digit BCD down-counter for countdown timing and preset
// division. All digits share clk; a combinational borrow chain decides which
// digits step on each enabled edge.
// Parameters:
//   DIGITS : number of BCD digits (1..8)
//   WRAP   : 1 = wrap 0 -> all-nines with an underflow pulse, 0 = hold at 0
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (count=0, underflow=0)
//   load      : synchronous load strobe, beats cnt_en
//   load_val  : BCD preset, digit 0 in [3:0]; nibbles A..F load as 9
//   cnt_en    : decrement by one on this edge
//   count     : registered BCD count
//   zero      : count == 0, decoded from the count register
//   underflow : one-cycle registered pulse after a 0 -> all-nines wrap
// -----------------------------------------------------------------------------
module bcd_sync_down_cntr
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                cnt_en,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                underflow
);

    logic [DIGITS:0]   borrow_s;
    logic [DIGITS-1:0] digit_zero_s;
    logic              all_zero_s;
    logic              underflow_q;
    logic              underflow_d;

    assign all_zero_s = &digit_zero_s;

    // In saturating mode an enabled edge at zero must not start the chain,
    // otherwise every digit would roll to 9.
    assign borrow_s[0] = cnt_en & ((WRAP == 1'b1) | ~all_zero_s);

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_nib   (load_val[4*g +: 4]),
            .borrow_in  (borrow_s[g]),
            .digit      (count[4*g +: 4]),
            .is_zero    (digit_zero_s[g]),
            .borrow_out (borrow_s[g+1])
        );
    end

    // A borrow leaving the top digit means the whole count rolled over.
    always_comb begin
        underflow_d = 1'b0;
        if (rst || load) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = borrow_s[DIGITS] & (WRAP == 1'b1);
        end
    end

    // Underflow pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign zero      = all_zero_s;
    assign underflow = underflow_q;

    bcd_sync_down_cntr_chk #(
        .DIGITS (DIGITS),
        .WRAP   (WRAP)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .zero      (zero),
        .underflow (underflow)
    );

endmodule : bcd_sync_down_cntr

// File: tb/tb_bcd_sync_down_cntr.sv
// -----------------------------------------------------------------------------
// tb_bcd_sync_down_cntr
// Directed bench for bcd_sync_down_cntr, DIGITS=4. Two instances share the
// stimulus: one wrapping (WRAP=1) and one saturating (WRAP=0).
// -----------------------------------------------------------------------------
module tb_bcd_sync_down_cntr;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        cnt_en;

    logic [15:0] cnt_w;
    logic        zero_w;
    logic        uf_w;
    logic [15:0] cnt_s;
    logic        zero_s;
    logic        uf_s;

    int n_cmp;
    int n_mis;
    int exp_dec;

    bcd_sync_down_cntr #(.DIGITS(4), .WRAP(1'b1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .cnt_en    (cnt_en),
        .count     (cnt_w),
        .zero      (zero_w),
        .underflow (uf_w)
    );

    bcd_sync_down_cntr #(.DIGITS(4), .WRAP(1'b0)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .cnt_en    (cnt_en),
        .count     (cnt_s),
        .zero      (zero_s),
        .underflow (uf_s)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and sample 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decimal 0..9999 to packed BCD.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] all_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return {15'd0, ok};
    endfunction

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 16'h1234;
        cnt_en   = 1'b1;

        // Reset overrides load and cnt_en.
        tick();
        chk("rst_count_w", cnt_w, 16'h0000);
        chk("rst_zero_w", {15'd0, zero_w}, 16'd1);
        chk("rst_uf_w", {15'd0, uf_w}, 16'd0);
        chk("rst_count_s", cnt_s, 16'h0000);

        // Hold after reset release.
        rst    = 1'b0;
        load   = 1'b0;
        cnt_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_zero_count", cnt_w, 16'h0000);
            chk("hold_zero_uf", {15'd0, uf_w}, 16'd0);
        end

        // Load 1000, then cascade borrow across three digits.
        load     = 1'b1;
        load_val = 16'h1000;
        tick();
        chk("load_1000", cnt_w, 16'h1000);
        chk("load_1000_zero", {15'd0, zero_w}, 16'd0);
        load   = 1'b0;
        cnt_en = 1'b1;
        tick();
        chk("cascade_0999", cnt_w, 16'h0999);
        exp_dec = 999;
        for (int i = 0; i < 999; i++) begin
            tick();
            exp_dec--;
            chk("cascade_count", cnt_w, to_bcd(exp_dec));
            chk("cascade_bcd", all_bcd(cnt_w), 16'd1);
            chk("cascade_zero", {15'd0, zero_w}, {15'd0, exp_dec == 0});
            chk("cascade_uf", {15'd0, uf_w}, 16'd0);
        end
        chk("cascade_end_s", cnt_s, 16'h0000);
        chk("cascade_end_zero_s", {15'd0, zero_s}, 16'd1);

        // Wrap: 0002 -> 0001 -> 0000 -> 9999 (pulse) -> 9998.
        cnt_en   = 1'b0;
        load     = 1'b1;
        load_val = 16'h0002;
        tick();
        chk("wrap_load", cnt_w, 16'h0002);
        load   = 1'b0;
        cnt_en = 1'b1;
        tick();
        chk("wrap_0001", cnt_w, 16'h0001);
        tick();
        chk("wrap_0000", cnt_w, 16'h0000);
        chk("wrap_0000_zero", {15'd0, zero_w}, 16'd1);
        chk("wrap_0000_uf", {15'd0, uf_w}, 16'd0);
        tick();
        chk("wrap_9999", cnt_w, 16'h9999);
        chk("wrap_uf_pulse", {15'd0, uf_w}, 16'd1);
        chk("wrap_9999_zero", {15'd0, zero_w}, 16'd0);
        chk("sat_at_wrap_s", cnt_s, 16'h0000);
        chk("sat_at_wrap_uf_s", {15'd0, uf_s}, 16'd0);
        tick();
        chk("wrap_9998", cnt_w, 16'h9998);
        chk("wrap_uf_end", {15'd0, uf_w}, 16'd0);

        // Saturate on the WRAP=0 instance.
        cnt_en   = 1'b0;
        load     = 1'b1;
        load_val = 16'h0001;
        tick();
        chk("sat_load", cnt_s, 16'h0001);
        load   = 1'b0;
        cnt_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_count", cnt_s, 16'h0000);
            chk("sat_zero", {15'd0, zero_s}, 16'd1);
            chk("sat_uf", {15'd0, uf_s}, 16'd0);
        end

        // Sanitise A..F to 9, then load beats cnt_en.
        cnt_en   = 1'b0;
        load     = 1'b1;
        load_val = 16'hF3A5;
        tick();
        chk("sanitise", cnt_w, 16'h9395);
        chk("sanitise_s", cnt_s, 16'h9395);
        load_val = 16'h0042;
        cnt_en   = 1'b1;
        tick();
        chk("load_wins", cnt_w, 16'h0042);
        load = 1'b0;
        tick();
        chk("after_load_dec", cnt_w, 16'h0041);
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_0041", cnt_w, 16'h0041);
            chk("hold_0041_uf", {15'd0, uf_w}, 16'd0);
        end

        // Mid-count reset.
        load     = 1'b1;
        load_val = 16'h5000;
        tick();
        load   = 1'b0;
        cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        chk("mid_4993", cnt_w, 16'h4993);
        rst = 1'b1;
        tick();
        chk("mid_rst_count", cnt_w, 16'h0000);
        chk("mid_rst_zero", {15'd0, zero_w}, 16'd1);
        rst    = 1'b0;
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_uf", {15'd0, uf_w}, 16'd0);
            chk("mid_rst_hold", cnt_w, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_bcd_sync_down_cntr
